// File: rtl/led_sequencer.sv
// LED pattern sequencer: IDLE/RUN/PAUSE FSM stepping one of four 8-bit patterns every DIV cycles.
// All outputs registered; first step DIV cycles after the start edge, run ends on the STEPS-th tick.
module led_sequencer #(
  parameter int DIV   = 12500000,
  parameter int STEPS = 16
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [1:0] SW,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  output logic [7:0] LEDG,
  output logic       busy,
  output logic       done
);

  localparam int             PW         = $clog2(DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
  localparam logic [7:0]     STEP_LAST  = 8'(STEPS - 1);

  localparam logic [1:0] MODE_BLINK = 2'b00;
  localparam logic [1:0] MODE_WALK  = 2'b01;
  localparam logic [1:0] MODE_PING  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    ledg_q, ledg_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    step_q, step_d;
  logic [1:0]    mode_q, mode_d;
  logic          dir_left_q, dir_left_d;

  logic [7:0]    next_pat;
  logic          next_dir_left;
  logic [7:0]    init_pat;
  logic          tick;
  logic          to_idle;

  always_comb begin
    case (SW)
      MODE_BLINK: init_pat = 8'hFF;
      MODE_WALK:  init_pat = 8'h01;
      MODE_PING:  init_pat = 8'h01;
      default:    init_pat = 8'h00;
    endcase
  end

  // Ping-pong turns around at either end rather than wrapping.
  always_comb begin
    next_pat      = ledg_q;
    next_dir_left = dir_left_q;
    case (mode_q)
      MODE_BLINK: next_pat = ~ledg_q;
      MODE_WALK:  next_pat = {ledg_q[6:0], ledg_q[7]};
      MODE_PING: begin
        if (dir_left_q) begin
          if (ledg_q == 8'h80) begin
            next_pat      = 8'h40;
            next_dir_left = 1'b0;
          end else begin
            next_pat = ledg_q << 1;
          end
        end else begin
          if (ledg_q == 8'h01) begin
            next_pat      = 8'h02;
            next_dir_left = 1'b1;
          end else begin
            next_pat = ledg_q >> 1;
          end
        end
      end
      default:    next_pat = ledg_q + 8'd1;
    endcase
  end

  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    state_d    = state_q;
    ledg_d     = ledg_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    presc_d    = presc_q;
    step_d     = step_q;
    mode_d     = mode_q;
    dir_left_d = dir_left_q;
    to_idle    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d    = RUN;
          mode_d     = SW;
          ledg_d     = init_pat;
          presc_d    = '0;
          step_d     = 8'd0;
          dir_left_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          to_idle = 1'b1;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (tick) begin
          presc_d = '0;
          if (step_q == STEP_LAST) begin
            to_idle = 1'b1;
            done_d  = 1'b1;
          end else begin
            ledg_d     = next_pat;
            dir_left_d = next_dir_left;
            step_d     = step_q + 8'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      PAUSE: begin
        if (stop) begin
          to_idle = 1'b1;
        end else if (!pause && start) begin
          state_d = RUN;
        end
      end
      default: to_idle = 1'b1;
    endcase

    if (to_idle) begin
      state_d = IDLE;
      ledg_d  = 8'h00;
      busy_d  = 1'b0;
      presc_d = '0;
      step_d  = 8'd0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      ledg_q     <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      presc_q    <= '0;
      step_q     <= 8'd0;
      mode_q     <= MODE_BLINK;
      dir_left_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ledg_q     <= ledg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      presc_q    <= presc_d;
      step_q     <= step_d;
      mode_q     <= mode_d;
      dir_left_q <= dir_left_d;
    end
  end

  assign LEDG = ledg_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Three sequencer instances (different DIV/STEPS) share one input stream; each is
// compared every cycle against a counter-based model, plus directed literal checks.
module tb_led_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] SW = 2'b00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;

  logic [2:0][7:0] ledg_o;
  logic [2:0]      busy_o;
  logic [2:0]      done_o;

  int DIVS   [3] = '{4, 4, 2};
  int STEPSS [3] = '{5, 12, 256};

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Model: state 0=idle 1=run 2=pause; k counts active run cycles since the start edge.
  int m_state [3];
  int m_k     [3];
  int m_mode  [3];
  bit m_done  [3];

  always #5 CLOCK_50 = ~CLOCK_50;

  led_sequencer #(.DIV(4), .STEPS(5)) u_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .SW(SW), .start(start), .pause(pause), .stop(stop),
    .LEDG(ledg_o[0]), .busy(busy_o[0]), .done(done_o[0]));
  led_sequencer #(.DIV(4), .STEPS(12)) u_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .SW(SW), .start(start), .pause(pause), .stop(stop),
    .LEDG(ledg_o[1]), .busy(busy_o[1]), .done(done_o[1]));
  led_sequencer #(.DIV(2), .STEPS(256)) u_c (
    .CLOCK_50(CLOCK_50), .reset(reset), .SW(SW), .start(start), .pause(pause), .stop(stop),
    .LEDG(ledg_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic logic [7:0] pat(int mode, int n);
    int p;
    case (mode)
      0:       return (n % 2 == 0) ? 8'hFF : 8'h00;
      1:       return 8'(1 << (n % 8));
      2: begin
        p = n % 14;
        return (p < 8) ? 8'(1 << p) : 8'(1 << (14 - p));
      end
      default: return 8'(n % 256);
    endcase
  endfunction

  always @(posedge CLOCK_50) begin
    for (int i = 0; i < 3; i++) begin
      m_done[i] = 1'b0;
      if (reset) begin
        m_state[i] = 0; m_k[i] = 0; m_mode[i] = 0;
      end else begin
        case (m_state[i])
          0: if (start && !stop) begin
               m_state[i] = 1; m_mode[i] = int'(SW); m_k[i] = 0;
             end
          1: if (stop) m_state[i] = 0;
             else if (pause) m_state[i] = 2;
             else begin
               m_k[i]++;
               if (m_k[i] == DIVS[i] * STEPSS[i]) begin
                 m_state[i] = 0; m_done[i] = 1'b1;
               end
             end
          default: if (stop) m_state[i] = 0;
                   else if (!pause && start) m_state[i] = 1;
        endcase
      end
    end
  end

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [7:0] exp_led;
        exp_led = (m_state[i] == 0) ? 8'h00 : pat(m_mode[i], m_k[i] / DIVS[i]);
        check($sformatf("model_ledg%0d", i), 32'(ledg_o[i]), 32'(exp_led));
        check($sformatf("model_busy%0d", i), 32'(busy_o[i]), 32'(m_state[i] != 0));
        check($sformatf("model_done%0d", i), 32'(done_o[i]), 32'(m_done[i]));
      end
    end
  end

  task automatic cyc();
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic clear_all();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    logic [7:0] walk_exp [5];
    logic [7:0] pp_exp [12];
    walk_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    pp_exp   = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                 8'h40, 8'h20, 8'h10, 8'h08};

    cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;
    check("reset_ledg", 32'(ledg_o[0]), 32'h00);
    check("reset_busy", 32'(busy_o[0]), 32'h0);
    check("reset_done", 32'(done_o[0]), 32'h0);

    // Walk, then an immediate restart on the cycle after done.
    SW = 2'b01; start = 1'b1;
    cyc();
    start = 1'b0;
    check("walk_first", 32'(ledg_o[0]), 32'(walk_exp[0]));
    check("walk_busy", 32'(busy_o[0]), 32'h1);
    for (int s = 1; s < 5; s++) begin
      repeat (3) cyc();
      check($sformatf("walk_hold%0d", s), 32'(ledg_o[0]), 32'(walk_exp[s-1]));
      cyc();
      check($sformatf("walk_step%0d", s), 32'(ledg_o[0]), 32'(walk_exp[s]));
    end
    repeat (3) cyc();
    check("walk_predone", 32'(done_o[0]), 32'h0);
    cyc();
    check("walk_done", 32'(done_o[0]), 32'h1);
    check("walk_end_ledg", 32'(ledg_o[0]), 32'h00);
    check("walk_end_busy", 32'(busy_o[0]), 32'h0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("restart_done_low", 32'(done_o[0]), 32'h0);
    check("restart_ledg", 32'(ledg_o[0]), 32'h01);
    check("restart_busy", 32'(busy_o[0]), 32'h1);
    clear_all();

    // Ping-pong on the STEPS=12 instance.
    SW = 2'b10; start = 1'b1;
    cyc();
    start = 1'b0;
    check("pp_0", 32'(ledg_o[1]), 32'(pp_exp[0]));
    for (int i = 1; i < 12; i++) begin
      repeat (4) cyc();
      check($sformatf("pp_%0d", i), 32'(ledg_o[1]), 32'(pp_exp[i]));
    end
    repeat (4) cyc();
    check("pp_done", 32'(done_o[1]), 32'h1);
    check("pp_end_ledg", 32'(ledg_o[1]), 32'h00);
    clear_all();

    // Count wrap on the DIV=2, STEPS=256 instance.
    SW = 2'b11; start = 1'b1;
    cyc();
    start = 1'b0;
    check("cnt_first", 32'(ledg_o[2]), 32'h00);
    repeat (510) cyc();
    check("cnt_ff", 32'(ledg_o[2]), 32'hFF);
    cyc();
    check("cnt_ff_hold", 32'(ledg_o[2]), 32'hFF);
    cyc();
    check("cnt_wrap_ledg", 32'(ledg_o[2]), 32'h00);
    check("cnt_wrap_done", 32'(done_o[2]), 32'h1);
    clear_all();

    // Pause after the 2nd step for 10 cycles, then resume.
    SW = 2'b01; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (8) cyc();
    check("pause_pre", 32'(ledg_o[0]), 32'h04);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check($sformatf("pause_ledg%0d", i), 32'(ledg_o[0]), 32'h04);
      check($sformatf("pause_busy%0d", i), 32'(busy_o[0]), 32'h1);
    end
    pause = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    check("resume_ledg", 32'(ledg_o[0]), 32'h04);
    repeat (3) cyc();
    check("resume_hold", 32'(ledg_o[0]), 32'h04);
    cyc();
    check("resume_step", 32'(ledg_o[0]), 32'h08);
    repeat (7) cyc();
    check("resume_last", 32'(ledg_o[0]), 32'h10);
    check("resume_predone", 32'(done_o[0]), 32'h0);
    cyc();
    check("resume_done", 32'(done_o[0]), 32'h1);
    clear_all();

    // Priority: start+stop in IDLE, then stop on the final tick.
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    check("prio_idle_busy", 32'(busy_o[0]), 32'h0);
    check("prio_idle_ledg", 32'(ledg_o[0]), 32'h00);
    SW = 2'b01; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (19) cyc();
    check("prio_pre_ledg", 32'(ledg_o[0]), 32'h10);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("prio_stop_done", 32'(done_o[0]), 32'h0);
    check("prio_stop_ledg", 32'(ledg_o[0]), 32'h00);
    check("prio_stop_busy", 32'(busy_o[0]), 32'h0);
    clear_all();

    // Reset mid-run in blink mode, then immediate fresh start.
    SW = 2'b00; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (2) cyc();
    check("blink_ff", 32'(ledg_o[0]), 32'hFF);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_run_ledg", 32'(ledg_o[0]), 32'h00);
    check("rst_run_busy", 32'(busy_o[0]), 32'h0);
    check("rst_run_done", 32'(done_o[0]), 32'h0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("rst_restart", 32'(ledg_o[0]), 32'hFF);
    repeat (3) cyc();
    check("rst_restart_hold", 32'(ledg_o[0]), 32'hFF);
    cyc();
    check("rst_restart_step", 32'(ledg_o[0]), 32'h00);
    check("rst_restart_busy", 32'(busy_o[0]), 32'h1);

    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 7) == 0);
      pause = ($urandom_range(0, 11) == 0);
      stop  = ($urandom_range(0, 99) == 0);
      SW    = 2'($urandom_range(0, 3));
      cyc();
    end
    reset = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter DIV, default 12500000, clock cycles per pattern step (4 Hz at 50 MHz); legal range is DIV >= 2.
REQ-002 Parameter STEPS, default 16, number of pattern steps per run; legal range is STEPS >= 1 and STEPS <= 256.
REQ-003 CLOCK_50  input  1  sole clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 SW  input  2  mode select, sampled only when a run starts.
REQ-006 start  input  1  level, sampled each cycle; starts a run from IDLE or resumes from PAUSE.
REQ-007 pause  input  1  level, sampled each cycle; freezes a run.
REQ-008 stop  input  1  level, sampled each cycle; aborts a run.
REQ-009 LEDG  output  8  registered LED pattern.
REQ-010 busy  output  1  high in RUN or PAUSE.
REQ-011 done  output  1  one-cycle pulse when a run completes normally.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, PAUSE; all outputs are registered.
REQ-013 Input priority each cycle SHALL be: stop first, then pause, then start.
REQ-014 IDLE: LEDG=8'h00, busy=0; on start the FSM SHALL go to RUN and latch SW into mode.
- Same edge: load the mode's initial pattern, clear the prescaler, clear step_cnt.
REQ-015 Initial pattern and step rule SHALL be per latched mode:
- 00 blink: 8'hFF; each step complements LEDG.
- 01 walk: 8'h01; each step rotates left; 8'h80 -> 8'h01.
- 10 ping-pong: 8'h01, direction left; each step shifts one place in the current direction.
  - Direction reverses when LEDG reaches 8'h80 (then 8'h40 next) or returns to 8'h01 (then 8'h02 next).
- 11 count: 8'h00; each step increments LEDG modulo 256 (8'hFF -> 8'h00).
REQ-016 Prescaler SHALL count 0..DIV-1 only in RUN; tick is asserted when the count equals DIV-1, and the count then wraps to 0.
REQ-017 On tick in RUN the FSM SHALL apply one pattern step and increment step_cnt.
- First step occurs DIV cycles after the start edge.
REQ-018 On the tick where step_cnt == STEPS-1, the FSM SHALL go to IDLE instead of stepping.
- On that edge: LEDG=8'h00, busy=0, done=1 for exactly one cycle.
REQ-019 pause in RUN SHALL go to PAUSE, holding LEDG, prescaler and step_cnt; a tick coinciding with pause SHALL be discarded (no step, prescaler held at its current value).
REQ-020 start in PAUSE with pause low SHALL return to RUN, resuming from the held prescaler and step_cnt values.
REQ-021 In PAUSE, pause high SHALL hold PAUSE even if start is also high.
REQ-022 stop in RUN or PAUSE SHALL go to IDLE on that edge with LEDG=8'h00, busy=0, done=0.
- stop wins over a coincident final tick, so done is not pulsed.
REQ-023 start while in RUN SHALL be ignored, and SW changes during RUN or PAUSE SHALL be ignored.
REQ-024 stop or pause in IDLE SHALL be ignored; start and stop together in IDLE SHALL remain in IDLE.
REQ-025 done SHALL never be high for more than one consecutive cycle.
- start high on the cycle after done SHALL begin a new run normally.

Reset
REQ-026 reset SHALL take priority over all inputs and, on the next posedge, force: state=IDLE, LEDG=8'h00, busy=0, done=0, prescaler=0, step_cnt=0, mode=00, direction=left.
REQ-027 reset asserted mid-run or in PAUSE SHALL abort without a done pulse; the block SHALL accept start on the first cycle after reset deasserts.

Verification (DIV=4, STEPS=5)
REQ-028 Walk mode:
- Stimulus: SW=01, start pulse.
- Response: LEDG 01 immediately after the start edge, then 02, 04, 08, 10 at 4-cycle intervals.
- The 5th tick gives LEDG=00 and done=1 for one cycle, 20 cycles after start.
REQ-029 Ping-pong mode:
- Stimulus: SW=10, STEPS=12.
- Response: LEDG sequence 01,02,04,08,10,20,40,80,40,20,10,08.
REQ-030 Count mode, wrap check:
- Stimulus: SW=11, STEPS=256, DIV=2.
- Response: LEDG reaches FF, then 00 is shown on the 256th step edge together with done; no X and no stall.
REQ-031 Pause/resume:
- Stimulus: pause for 10 cycles after the 2nd step, then a start pulse.
- Response: LEDG is frozen and busy=1 throughout; the next step occurs exactly at the remaining prescaler count; total run is 20 active cycles.
REQ-032 Priority:
- Stimulus: start and stop in the same cycle in IDLE, then stop coincident with the final tick.
- Response: stays in IDLE; no done pulse; LEDG=00.
REQ-033 Reset mid-run:
- Stimulus: reset during blink mode with LEDG=FF.
- Response: next edge gives LEDG=00, busy=0, done=0; a start on the next cycle begins a fresh run from step 0.
